// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, FSM state type and S-box lookup for the
// inverse key schedule.
package aes_pkg;
  localparam logic [1:0] MODE_AES128 = 2'b00;
  localparam logic [1:0] MODE_AES256 = 2'b10;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  // Index 0 and 11..15 are never used; zero keeps the lookup total.
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction
endpackage

// File: rtl/aes_inv_keystep.sv
// aes_inv_keystep: one combinational backward step of the AES key schedule.
// Window is {newer key, older key}; the newer key is the one being emitted.
module aes_inv_keystep
  import aes_pkg::*;
(
  input  logic [255:0] win,
  input  logic [1:0]   mode,
  input  logic [3:0]   rd,
  output logic [255:0] win_next
);
  logic        is128;
  logic        rot;
  logic [3:0]  ridx;
  logic [31:0] n0, n1, n2, n3, d0, d1, d2, d3, x, s_in, s_out;
  assign is128 = mode == MODE_AES128;
  assign {n0, n1, n2, n3} = win[255:128];
  assign d3 = n3 ^ n2;
  assign d2 = n2 ^ n1;
  assign d1 = n1 ^ n0;
  // AES-256 rotates and adds Rcon only on even round indices (word index mod 8 == 0).
  assign rot   = is128 | ~rd[0];
  assign ridx  = is128 ? rd : {1'b0, rd[3:1]};
  assign x     = is128 ? d3 : win[31:0];
  assign s_in  = rot ? {x[23:0], x[31:24]} : x;
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign s_out[8*i +: 8] = sbox(s_in[8*i +: 8]);
  end
  assign d0 = n0 ^ s_out ^ (rot ? {RCON[ridx], 24'h0} : 32'h0);
  assign win_next = is128 ? {d0, d1, d2, d3, win[127:0]} : {win[127:0], d0, d1, d2, d3};
endmodule

// File: rtl/aes_inv_keysched.sv
// aes_inv_keysched: streams AES round keys backward (last key down to RK0)
// with a valid/ready handshake, one key per cycle when unstalled.
module aes_inv_keysched
  import aes_pkg::*;
#(
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [KEY_W-1:0] current_key,
  input  logic [KEY_W-1:0] prev_key,
  output logic [KEY_W-1:0] round_key,
  output logic [3:0]       RD,
  output logic             out_valid,
  output logic             done,
  output logic             busy,
  output logic             err,
  input  logic             out_ready
);
  state_t               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [2*KEY_W-1:0]   win_q, win_d, win_step;
  logic [3:0]           rd_q, rd_d;
  logic                 out_valid_q, out_valid_d, done_q, done_d;
  logic                 busy_q, busy_d, err_q, err_d;
  logic                 supported;
  aes_inv_keystep u_step (
    .win      (win_q),
    .mode     (mode_q),
    .rd       (rd_q),
    .win_next (win_step)
  );
  assign supported = mode == MODE_AES128 || mode == MODE_AES256;
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    win_d       = win_q;
    rd_d        = rd_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    busy_d      = busy_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (supported) begin
          state_d     = RUN;
          mode_d      = mode;
          win_d       = {current_key, mode == MODE_AES128 ? {KEY_W{1'b0}} : prev_key};
          rd_d        = mode == MODE_AES128 ? 4'd10 : 4'd14;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      RUN: if (out_valid_q && out_ready) begin
        if (rd_q == 4'd0) begin
          state_d     = FIN;
          out_valid_d = 1'b0;
          done_d      = 1'b1;
        end else begin
          win_d = win_step;
          rd_d  = rd_q - 4'd1;
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      win_q       <= '0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      win_q       <= win_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end
  assign round_key = win_q[2*KEY_W-1:KEY_W];
  assign RD        = rd_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign err       = err_q;
endmodule

// File: tb/tb_aes_inv_keysched.sv
// tb_aes_inv_keysched: expands keys forward with a GF(2^8)-derived reference
// and checks the DUT streams the same round keys backward.
module tb_aes_inv_keysched;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         out_ready = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [127:0] current_key = '0;
  logic [127:0] prev_key = '0;
  logic [127:0] round_key;
  logic [3:0]   rd;
  logic         out_valid, done, busy, err;
  int           n_cmp = 0;
  int           n_err = 0;
  logic [7:0]   sb [256];
  logic [127:0] rk_exp [15];
  logic [127:0] got_rk0, got_rk1;
  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  aes_inv_keysched #(.KEY_W(128)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .current_key (current_key),
    .prev_key    (prev_key),
    .round_key   (round_key),
    .RD          (rd),
    .out_valid   (out_valid),
    .done        (done),
    .busy        (busy),
    .err         (err),
    .out_ready   (out_ready)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    repeat (n) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Standard forward expansion; round key r is words 4r..4r+3.
  task automatic expand(input bit is256, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int nk = is256 ? 8 : 4;
    int tot = is256 ? 60 : 44;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < tot; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < tot / 4; r++) rk_exp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_seq(input bit is256, input logic [255:0] key, input bit bp, input bit inject);
    int nr, idx, cyc;
    bit rdy;
    expand(is256, key);
    nr = is256 ? 14 : 10;
    mode = is256 ? 2'b10 : 2'b00;
    current_key = rk_exp[nr];
    prev_key = is256 ? rk_exp[nr-1] : rnd128();
    start = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    idx = nr;
    cyc = 0;
    while (idx >= 0 && cyc < 200) begin
      check("out_valid", out_valid, 1);
      check("rd", rd, idx);
      check("round_key", round_key, rk_exp[idx]);
      check("err_in_run", err, 0);
      if (idx == 0) got_rk0 = round_key;
      if (idx == 1) got_rk1 = round_key;
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (inject) begin
        start = 1'($urandom_range(0, 1));
        mode = 2'($urandom);
        current_key = rnd128();
        prev_key = rnd128();
      end
      @(negedge clk);
      if (rdy) idx--;
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    check("seq_in_budget", 1'(idx < 0), 1);
    check("fin_valid", out_valid, 0);
    check("fin_done", done, 1);
    check("fin_busy", busy, 1);
    @(negedge clk);
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    build_sbox();
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rd", rd, 0);
    check("rst_key", round_key, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_seq(1'b0, {K128, 128'h0}, 1'b0, 1'b0);
    check("v128_rk0", got_rk0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    run_seq(1'b1, K256, 1'b0, 1'b0);
    check("v256_rk1", got_rk1, 128'h1f352c073b6108d72d9810a30914dff4);
    check("v256_rk0", got_rk0, 128'h603deb1015ca71be2b73aef0857d7781);
    run_seq(1'b0, {K128, 128'h0}, 1'b1, 1'b0);
    check("bp128_rk0", got_rk0, 128'h2b7e151628aed2a6abf7158809cf4f3c);

    for (int m = 1; m < 4; m += 2) begin
      mode = 2'(m);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("err_pulse", err, 1);
      check("err_busy", busy, 0);
      check("err_valid", out_valid, 0);
      @(negedge clk);
      check("err_clear", err, 0);
      check("err_idle_busy", busy, 0);
    end

    run_seq(1'b1, {rnd128(), rnd128()}, 1'b1, 1'b1);
    run_seq(1'b0, {rnd128(), 128'h0}, 1'b1, 1'b1);
    repeat (4) run_seq(1'($urandom_range(0, 1)), {rnd128(), rnd128()}, 1'b1, 1'b1);

    expand(1'b1, K256);
    mode = 2'b10;
    current_key = rk_exp[14];
    prev_key = rk_exp[13];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (rd != 4'd5 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_rd5", rd, 5);
    check("mid_key5", round_key, rk_exp[5]);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd", rd, 0);
    check("mid_rst_key", round_key, 0);
    out_ready = 1'b0;
    @(negedge clk);
    check("mid_rst_hold_valid", out_valid, 0);
    check("mid_rst_hold_done", done, 0);
    check("mid_rst_hold_err", err, 0);
    rst_n = 1'b1;
    run_seq(1'b0, {K128, 128'h0}, 1'b0, 1'b0);
    check("post_rst_rk0", got_rk0, 128'h2b7e151628aed2a6abf7158809cf4f3c);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
